imem_loader: RTL

Boot-time instruction-memory writer for the single-cycle RISC-V core. Receives a length-prefixed, checksummed byte stream over a valid/ready interface, assembles little-endian 32-bit words, and issues one write per word into the instruction memory's write port. It holds the core in reset until a load completes cleanly.

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a length-prefixed, checksummed byte stream and writes one 32-bit
// little-endian word per write strobe. The core stays in reset until a load
// finishes with a matching checksum.
//
// Handshake: a byte moves on a rising edge where rx_valid && rx_ready are
// both high. rx_ready depends only on the registered state, so the sender may
// hold rx_valid/rx_data steady until the transfer happens.
module imem_loader #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam logic [31:0] DEPTH_LIMIT  = 32'(DEPTH_WORDS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    // S_CHECK is a one-cycle evaluation step after the checksum byte; it keeps
    // rx_ready low and spaces the last write from the core_rst release.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] index;
    logic [31:0] len;
    logic [23:0] asm_word;
    logic [7:0]  sum;
    logic [31:0] idle_cnt;
    logic        csum_ok;

    logic        accept;
    logic        start_ok;
    logic        timeout_hit;
    logic [31:0] len_full;

    assign busy        = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign rx_ready    = busy;
    assign done        = (state == S_DONE);
    assign err         = (state == S_ERR);
    assign core_rst    = (state != S_DONE);
    assign state_dbg   = state;
    assign accept      = rx_valid && rx_ready;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign timeout_hit = busy && !accept && (idle_cnt == TIMEOUT_LAST);
    assign len_full    = {rx_data, len[23:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a timeout while waiting for a byte overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_LEN;
            end
            S_LEN: begin
                if (timeout_hit) begin
                    state_next = S_ERR;
                end else if (accept && byte_cnt == 2'd3) begin
                    if (len_full > DEPTH_LIMIT)  state_next = S_ERR;
                    else if (len_full == 32'd0)  state_next = S_CSUM;
                    else                         state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (timeout_hit) begin
                    state_next = S_ERR;
                end else if (accept && byte_cnt == 2'd3 && (index + 32'd1) == len) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (timeout_hit)  state_next = S_ERR;
                else if (accept)  state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = csum_ok ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start_ok) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: byte assembly, running sum, idle timer and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            index    <= 32'd0;
            len      <= 32'd0;
            asm_word <= 24'd0;
            sum      <= 8'd0;
            idle_cnt <= 32'd0;
            csum_ok  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                byte_cnt <= 2'd0;
                index    <= 32'd0;
                len      <= 32'd0;
                sum      <= 8'd0;
                idle_cnt <= 32'd0;
            end else if (busy) begin
                idle_cnt <= accept ? 32'd0 : idle_cnt + 32'd1;
                if (accept) begin
                    case (state)
                        S_LEN: begin
                            byte_cnt <= byte_cnt + 2'd1;
                            case (byte_cnt)
                                2'd0:    len[7:0]   <= rx_data;
                                2'd1:    len[15:8]  <= rx_data;
                                2'd2:    len[23:16] <= rx_data;
                                default: len[31:24] <= rx_data;
                            endcase
                        end
                        S_DATA: begin
                            byte_cnt <= byte_cnt + 2'd1;
                            sum      <= sum + rx_data;
                            case (byte_cnt)
                                2'd0:    asm_word[7:0]   <= rx_data;
                                2'd1:    asm_word[15:8]  <= rx_data;
                                2'd2:    asm_word[23:16] <= rx_data;
                                default: begin
                                    wr_en   <= 1'b1;
                                    wr_data <= {rx_data, asm_word};
                                    wr_addr <= {index[29:0], 2'b00};
                                    index   <= index + 32'd1;
                                end
                            endcase
                        end
                        S_CSUM: begin
                            csum_ok <= (rx_data == sum);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
